mpu_elementwise: RTL
====================

# mpu_elementwise

Sequential, parametrised element-wise matrix unit for the MPU datapath; successor to the combinational 5x5 8-bit adder. Computes R = A op B over SIZE x SIZE matrices of WIDTH-bit elements, LANES elements per cycle, with add/sub in wrapping or signed-saturating mode. Operands are captured on a start handshake, the result is built beat by beat, and a done pulse marks completion. A sticky overflow flag is also reported.

## Interface
- SIZE, 5: matrix dimension (SIZE x SIZE elements), >= 1
- WIDTH, 8: element width in bits, >= 2
- LANES, 5: elements processed per beat, 1..SIZE*SIZE
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; accepted only in IDLE
- op  in  2  00 add wrap, 01 sub wrap, 10 add signed-saturate, 11 sub signed-saturate
- matrix_a  in  SIZE*SIZE*WIDTH  operand A, flattened
- matrix_b  in  SIZE*SIZE*WIDTH  operand B, flattened
- busy  out  1  high while in BUSY
- done  out  1  one-cycle completion pulse
- result  out  SIZE*SIZE*WIDTH  registered result, flattened
- overflow  out  1  sticky: any element signed-overflowed in current/last operation

## Operation
- Element (i,j) occupies bits [WIDTH*(i+SIZE*j) +: WIDTH] in all three matrix ports; element index k = i+SIZE*j.
- BEATS = ceil(SIZE*SIZE/LANES). Beat n processes k = n*LANES .. n*LANES+LANES-1; lanes with k >= SIZE*SIZE are inert (no write, no overflow contribution).
- FSM: IDLE -> BUSY on start; BUSY -> DONE after beat BEATS-1; DONE -> IDLE unconditionally.
- On accepted start: capture matrix_a, matrix_b, op into internal registers; clear result to 0, overflow to 0, beat counter to 0. Inputs may change freely afterwards.
- start in BUSY or DONE: ignored, no effect.
- Arithmetic per element, on captured operands, treated as two's-complement signed: wrap modes write the low WIDTH bits of a+b / a-b; saturating modes clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Overflow detection (all modes): the exact signed result lies outside the WIDTH-bit signed range; overflow ORs in each beat's detections.
- result and overflow hold after DONE until the next accepted start.
- rst: state IDLE, busy 0, done 0, result 0, overflow 0, counter 0, captured registers 0. rst mid-operation aborts with no done pulse; rst wins over simultaneous start.

## Timing
- start sampled high in IDLE at edge t: busy = 1 for cycles t+1 .. t+BEATS; beat n's elements are visible on result after edge t+n+1.
- done = 1 only in cycle t+BEATS+1 (DONE), busy = 0 there; result/overflow final and stable from that cycle.
- Earliest next accepted start: cycle t+BEATS+2 (IDLE). Operation-to-operation throughput: BEATS+2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package mpu_pkg: op encoding localparams (OP_ADD, OP_SUB, OP_ADDS, OP_SUBS), FSM state encoding, helper function for BEATS (ceiling divide).
- Sub-module mpu_lane: combinational single-element op (WIDTH parameter; a, b, op -> r, ovf); instantiated LANES times by a generate loop.
- Top: FSM, beat counter of width $clog2(BEATS+1), operand/op capture registers, lane-to-element muxing and result write enables.

## Test plan
- Defaults, op=00, A elements 1..25 (k order), B 25..1 -> every element 26 (0x1A), overflow 0; busy for 5 cycles, done in cycle t+6.
- op=01, all A=0, B=1 -> every element 0xFF, overflow 0; op=00 with A=100, B=100 -> 0xC8, overflow 1.
- op=10 A=100, B=100 -> 0x7F, overflow 1; op=11 A=0x80 (-128), B=1 -> 0x80, overflow 1; op=11 A=5, B=3 -> 0x02, overflow 0.
- start pulsed every cycle from t with changing operands -> only the t operands used, next acceptance at t+7, exactly one done per operation.
- rst asserted at cycle t+3 of an operation -> next cycle busy 0, result 0, overflow 0, no done pulse; fresh start then completes normally.
- SIZE=4, LANES=3 (BEATS=6, last beat one live lane), op=00 with A=k, B=2k -> element k equals 3k, done at t+7, untouched bits never disturbed.

Source files
------------

// File: rtl/mpu_elementwise_pkg.sv
// rtl/mpu_elementwise_pkg.sv - shared op encodings, FSM states and sizing helper for the element-wise unit
package mpu_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ADDS = 2'b10;
    localparam logic [1:0] OP_SUBS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of beats needed to cover num elements at den elements per beat.
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/mpu_elementwise_if.sv
// rtl/mpu_elementwise_if.sv - request/result bundle between a host and the element-wise unit
interface mpu_elementwise_if #(
    parameter int SIZE  = 5,
    parameter int WIDTH = 8
);
    localparam int MW = SIZE * SIZE * WIDTH;

    logic          start;
    logic [1:0]    op;
    logic [MW-1:0] matrix_a;
    logic [MW-1:0] matrix_b;
    logic          busy;
    logic          done;
    logic [MW-1:0] result;
    logic          overflow;

    modport master (
        output start, op, matrix_a, matrix_b,
        input  busy, done, result, overflow
    );

    modport slave (
        input  start, op, matrix_a, matrix_b,
        output busy, done, result, overflow
    );

endinterface

// File: rtl/mpu_elementwise_lane.sv
// rtl/mpu_elementwise_lane.sv - single-element add/sub with wrap or signed saturation
module mpu_lane
    import mpu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       op_i,
    output logic [WIDTH-1:0] r_o,
    output logic             ovf_o
);

    logic [WIDTH:0] ext;
    logic           ovf;
    logic           is_sub;
    logic           is_sat;

    // One extra sign bit holds the exact result; overflow when the top two bits disagree.
    always_comb begin
        is_sub = (op_i == OP_SUB) || (op_i == OP_SUBS);
        is_sat = (op_i == OP_ADDS) || (op_i == OP_SUBS);
        if (is_sub) begin
            ext = {a_i[WIDTH-1], a_i} - {b_i[WIDTH-1], b_i};
        end else begin
            ext = {a_i[WIDTH-1], a_i} + {b_i[WIDTH-1], b_i};
        end
        ovf   = ext[WIDTH] ^ ext[WIDTH-1];
        ovf_o = ovf;
        r_o   = ext[WIDTH-1:0];
        if (ovf && is_sat) begin
            r_o = ext[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/mpu_elementwise.sv
// rtl/mpu_elementwise.sv - sequential element-wise matrix add/sub, LANES elements per beat
module mpu_elementwise
    import mpu_pkg::*;
#(
    parameter int SIZE  = 5,
    parameter int WIDTH = 8,
    parameter int LANES = 5
) (
    input  logic             clk,
    input  logic             rst,
    mpu_elementwise_if.slave bus
);

    localparam int N     = SIZE * SIZE;
    localparam int MW    = N * WIDTH;
    localparam int BEATS = ceil_div(N, LANES);
    localparam int CW    = $clog2(BEATS + 1);
    localparam int KW    = $clog2(BEATS * LANES + 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     beat_q, beat_d;
    logic [MW-1:0]     a_q, b_q, result_q;
    logic [1:0]        op_q;
    logic              ovf_q;
    logic              accept;
    logic              last_beat;

    logic [WIDTH-1:0]  lane_a [LANES];
    logic [WIDTH-1:0]  lane_b [LANES];
    logic [WIDTH-1:0]  lane_r [LANES];
    logic [KW-1:0]     lane_k [LANES];
    logic [LANES-1:0]  lane_live;
    logic [LANES-1:0]  lane_ovf;

    assign accept    = (state_q == ST_IDLE) && bus.start;
    assign last_beat = (beat_q == CW'(BEATS - 1));

    // State and beat counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Next state: one BUSY cycle per beat, then a single DONE cycle.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_BUSY;
                    beat_d  = '0;
                end
            end
            ST_BUSY: begin
                if (last_beat) begin
                    state_d = ST_DONE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operands are latched on accept so the host may change its inputs during the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
        end else if (accept) begin
            a_q  <= bus.matrix_a;
            b_q  <= bus.matrix_b;
            op_q <= bus.op;
        end
    end

    // Lanes past the last element are forced to index 0 and masked by lane_live.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [KW-1:0] k_raw;
        assign k_raw        = KW'(beat_q) * KW'(LANES) + KW'(l);
        assign lane_live[l] = (k_raw < KW'(N));
        assign lane_k[l]    = lane_live[l] ? k_raw : '0;
        assign lane_a[l]    = a_q[int'(lane_k[l]) * WIDTH +: WIDTH];
        assign lane_b[l]    = b_q[int'(lane_k[l]) * WIDTH +: WIDTH];

        mpu_lane #(.WIDTH(WIDTH)) u_lane (
            .a_i   (lane_a[l]),
            .b_i   (lane_b[l]),
            .op_i  (op_q),
            .r_o   (lane_r[l]),
            .ovf_o (lane_ovf[l])
        );
    end

    // Result and sticky overflow: cleared on accept, filled beat by beat, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else if (state_q == ST_BUSY) begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_live[l]) begin
                    result_q[int'(lane_k[l]) * WIDTH +: WIDTH] <= lane_r[l];
                end
            end
            ovf_q <= ovf_q | (|(lane_ovf & lane_live));
        end
    end

    assign bus.busy     = (state_q == ST_BUSY);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.result   = result_q;
    assign bus.overflow = ovf_q;

endmodule
